// File: rtl/bcd_counter_nd.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter_nd
//  Purpose  : Cascaded N-digit BCD counter. It counts up or down and has a
//             count enable, a built-in prescaler, synchronous clear and load,
//             and a registered one-cycle wrap pulse.
//  Ports    : clk_i       - system clock, rising edge
//             rst_n_i     - asynchronous active-low reset
//             en_i        - count enable, gates the prescaler
//             up_i        - direction: 1 = up, 0 = down
//             clr_i       - synchronous clear (highest priority)
//             load_i      - synchronous load of load_val_i
//             load_val_i  - BCD load value, digit k in [4k+3:4k]
//             cnt_o       - registered BCD count
//             wrap_o      - one-cycle pulse on MAX->0 or 0->MAX
//  Options  : define BCD_COUNTER_SATURATE_EN to saturate at 0 / MAX instead
//             of wrapping. wrap_o is then held low.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_nd #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   cnt_o,
    output logic                  wrap_o
);

    localparam int c_PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);

    logic [c_PRE_W-1:0]  r_pre;
    logic [4*DIGITS-1:0] r_cnt;
    logic                r_wrap;

    logic                w_pre_last;
    logic                w_step;
    logic [DIGITS-1:0]   w_edge;      // digit at 9 (up) or at 0 (down)
    logic [DIGITS:0]     w_chain;     // carry/borrow into digit k
    logic [4*DIGITS-1:0] w_stepped;   // count after one step
    logic [4*DIGITS-1:0] w_load_bcd;  // load value with nibbles clamped to 9

    assign w_pre_last = (r_pre == c_PRE_LAST);
    assign w_step     = en_i & w_pre_last;

    // Per-digit increment/decrement and load clamping.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] w_d;
        logic [3:0] w_lv;
        logic [3:0] w_inc;
        logic [3:0] w_dec;

        assign w_d   = r_cnt[4*k +: 4];
        assign w_lv  = load_val_i[4*k +: 4];
        assign w_inc = (w_d == 4'd9) ? 4'd0 : (w_d + 4'd1);
        assign w_dec = (w_d == 4'd0) ? 4'd9 : (w_d - 4'd1);

        assign w_edge[k] = up_i ? (w_d == 4'd9) : (w_d == 4'd0);

        // A digit only moves when every lower digit rolls over.
        assign w_stepped[4*k +: 4] = !w_chain[k] ? w_d : (up_i ? w_inc : w_dec);
        assign w_load_bcd[4*k +: 4] = (w_lv > 4'd9) ? 4'd9 : w_lv;
    end

    // Ripple chain: the carry out of the top digit marks a full wrap.
    always_comb begin
        w_chain[0] = 1'b1;
        for (int k = 1; k <= DIGITS; k++) begin
            w_chain[k] = w_chain[k-1] & w_edge[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt  <= '0;
            r_pre  <= '0;
            r_wrap <= 1'b0;
        end else if (clr_i) begin
            r_cnt  <= '0;
            r_pre  <= '0;
            r_wrap <= 1'b0;
        end else if (load_i) begin
            r_cnt  <= w_load_bcd;
            r_pre  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (en_i) begin
                r_pre <= w_pre_last ? '0 : (r_pre + c_PRE_W'(1));
            end
            if (w_step) begin
`ifdef BCD_COUNTER_SATURATE_EN
                // At the end of the range the count stays put.
                if (!w_chain[DIGITS]) begin
                    r_cnt <= w_stepped;
                end
`else
                r_cnt  <= w_stepped;
                r_wrap <= w_chain[DIGITS];
`endif
            end
        end
    end

    assign cnt_o  = r_cnt;
    assign wrap_o = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_nd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_counter_nd
//  Purpose  : Directed self-checking bench for bcd_counter_nd. It uses three
//             instances: a 2-digit instance with no prescale, a 2-digit
//             instance with prescale 4, and a 3-digit instance with no
//             prescale.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_nd;

`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit c_SAT = 1'b1;
`else
    localparam bit c_SAT = 1'b0;
`endif

    logic clk;
    logic rst_n;

    logic       en_a, up_a, clr_a, load_a, wrap_a;
    logic [7:0] lv_a, cnt_a;
    logic       en_b, up_b, clr_b, load_b, wrap_b;
    logic [7:0] lv_b, cnt_b;
    logic        en_c, up_c, clr_c, load_c, wrap_c;
    logic [11:0] lv_c, cnt_c;

    int n_checks = 0;
    int n_errors = 0;
    logic wrap_seen;

    bcd_counter_nd #(.DIGITS(2), .PRESCALE(1)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en_a), .up_i(up_a), .clr_i(clr_a),
        .load_i(load_a), .load_val_i(lv_a), .cnt_o(cnt_a), .wrap_o(wrap_a)
    );
    bcd_counter_nd #(.DIGITS(2), .PRESCALE(4)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en_b), .up_i(up_b), .clr_i(clr_b),
        .load_i(load_b), .load_val_i(lv_b), .cnt_o(cnt_b), .wrap_o(wrap_b)
    );
    bcd_counter_nd #(.DIGITS(3), .PRESCALE(1)) u_dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en_c), .up_i(up_c), .clr_i(clr_c),
        .load_i(load_c), .load_val_i(lv_c), .cnt_o(cnt_c), .wrap_o(wrap_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, settling 1 time unit after each edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {en_a, up_a, clr_a, load_a, lv_a} = '0;
        {en_b, up_b, clr_b, load_b, lv_b} = '0;
        {en_c, up_c, clr_c, load_c, lv_c} = '0;

        // ---------------- reset and basic up count ----------------
        tick(3);
        check("rst_cnt_a", 32'(cnt_a), 32'h00);
        check("rst_wrap_a", 32'(wrap_a), 32'h0);
        check("rst_cnt_b", 32'(cnt_b), 32'h00);
        check("rst_cnt_c", 32'(cnt_c), 32'h000);

        rst_n = 1'b1;
        en_a  = 1'b1;
        up_a  = 1'b1;
        wrap_seen = 1'b0;
        tick(1);
        check("first_step", 32'(cnt_a), 32'h01);
        for (int i = 0; i < 11; i++) begin
            tick(1);
            wrap_seen |= wrap_a;
        end
        check("up12", 32'(cnt_a), 32'h12);
        check("up12_nowrap", 32'(wrap_seen), 32'h0);

        // ---------------- wrap up then down ----------------
        load_a = 1'b1; lv_a = 8'h98;
        tick(1);
        check("load98", 32'(cnt_a), 32'h98);
        check("load98_wrap", 32'(wrap_a), 32'h0);
        load_a = 1'b0;
        tick(1);
        check("up_99", 32'(cnt_a), 32'h99);
        tick(1);
        check("up_wrap_cnt", 32'(cnt_a), c_SAT ? 32'h99 : 32'h00);
        check("up_wrap_pulse", 32'(wrap_a), c_SAT ? 32'h0 : 32'h1);
        up_a = 1'b0;
        tick(1);
        check("dn_wrap_cnt", 32'(cnt_a), c_SAT ? 32'h98 : 32'h99);
        check("dn_wrap_pulse", 32'(wrap_a), c_SAT ? 32'h0 : 32'h1);
        tick(1);
        check("dn_next", 32'(cnt_a), c_SAT ? 32'h97 : 32'h98);
        check("dn_next_wrap", 32'(wrap_a), 32'h0);

        // Borrow across a digit boundary.
        load_a = 1'b1; lv_a = 8'h40;
        tick(1);
        load_a = 1'b0;
        tick(1);
        check("borrow_40", 32'(cnt_a), 32'h39);

        // Hold while disabled; direction ignored.
        en_a = 1'b0; up_a = 1'b1;
        tick(2);
        check("hold", 32'(cnt_a), 32'h39);
        check("hold_wrap", 32'(wrap_a), 32'h0);

        // ---------------- priority and clamp ----------------
        en_a = 1'b1; clr_a = 1'b1; load_a = 1'b1; lv_a = 8'h57;
        tick(1);
        check("clr_over_load", 32'(cnt_a), 32'h00);
        clr_a = 1'b0; lv_a = 8'hA3;
        tick(1);
        check("clamp_A3", 32'(cnt_a), 32'h93);
        lv_a = 8'hFC;
        tick(1);
        check("clamp_FC", 32'(cnt_a), 32'h99);

        // ---------------- async reset between edges ----------------
        lv_a = 8'h37; en_a = 1'b0;
        tick(1);
        load_a = 1'b0;
        check("pre_async_37", 32'(cnt_a), 32'h37);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cnt", 32'(cnt_a), 32'h00);
        #1 rst_n = 1'b1;
        tick(1);
        check("after_async", 32'(cnt_a), 32'h00);

        // ---------------- prescaler (PRESCALE = 4) ----------------
        en_b = 1'b1; up_b = 1'b1;
        wrap_seen = 1'b0;
        tick(3);
        check("pre_3cyc", 32'(cnt_b), 32'h00);
        tick(1);
        check("pre_4cyc", 32'(cnt_b), 32'h01);
        tick(12);
        check("pre_16cyc", 32'(cnt_b), 32'h04);
        en_b = 1'b0;
        tick(3);
        check("pre_disabled", 32'(cnt_b), 32'h04);
        en_b = 1'b1;
        tick(3);
        check("pre_resume3", 32'(cnt_b), 32'h04);
        tick(1);
        check("pre_resume4", 32'(cnt_b), 32'h05);

        // A load clears the prescaler.
        tick(2);
        load_b = 1'b1; lv_b = 8'hA3;
        tick(1);
        load_b = 1'b0;
        check("pre_load", 32'(cnt_b), 32'h93);
        tick(3);
        check("pre_load_3", 32'(cnt_b), 32'h93);
        tick(1);
        check("pre_load_4", 32'(cnt_b), 32'h94);

        // Async reset mid-prescale restarts the prescaler.
        tick(2);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick(3);
        check("pre_rst_3", 32'(cnt_b), 32'h00);
        tick(1);
        check("pre_rst_4", 32'(cnt_b), 32'h01);
        check("pre_wrap", 32'(wrap_b), 32'h0);
        en_b = 1'b0;

        // ---------------- 3 digits: full ripple ----------------
        en_c = 1'b1; up_c = 1'b1; load_c = 1'b1; lv_c = 12'h998;
        tick(1);
        load_c = 1'b0;
        tick(1);
        check("c_up1", 32'(cnt_c), 32'h999);
        tick(1);
        check("c_up2", 32'(cnt_c), c_SAT ? 32'h999 : 32'h000);
        check("c_up2_wrap", 32'(wrap_c), c_SAT ? 32'h0 : 32'h1);
        tick(1);
        check("c_up3", 32'(cnt_c), c_SAT ? 32'h999 : 32'h001);
        check("c_up3_wrap", 32'(wrap_c), 32'h0);

        load_c = 1'b1; lv_c = 12'h001; up_c = 1'b0;
        tick(1);
        load_c = 1'b0;
        tick(1);
        check("c_dn1", 32'(cnt_c), 32'h000);
        tick(1);
        check("c_dn2", 32'(cnt_c), c_SAT ? 32'h000 : 32'h999);
        check("c_dn2_wrap", 32'(wrap_c), c_SAT ? 32'h0 : 32'h1);

        load_c = 1'b1; lv_c = 12'h100;
        tick(1);
        load_c = 1'b0;
        tick(1);
        check("c_borrow", 32'(cnt_c), 32'h099);
        up_c = 1'b1;
        tick(1);
        check("c_carry", 32'(cnt_c), 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
